// File: rtl/multicycle_ctl_pkg.sv
// Shared definitions for the multi-cycle RV32 sequencer.
//  - state_e : FSM state encoding (also driven on the debug state port)
//  - OPC_*   : major opcodes (ir[6:0]) recognised by the decoder
//  - ALU_*   : ALU operation codes driven on op
//  - CLS_*   : bit positions of the one-hot instruction class vector
//  - is_last : true in the final state of an instruction's path
package multicycle_ctl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   localparam logic [6:0] OPC_R     = 7'h33;
   localparam logic [6:0] OPC_IALU  = 7'h13;
   localparam logic [6:0] OPC_LOAD  = 7'h03;
   localparam logic [6:0] OPC_STORE = 7'h23;
   localparam logic [6:0] OPC_BR    = 7'h63;
   localparam logic [6:0] OPC_JAL   = 7'h6f;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   localparam int CLS_W     = 7;
   localparam int CLS_R     = 0;
   localparam int CLS_IALU  = 1;
   localparam int CLS_LOAD  = 2;
   localparam int CLS_STORE = 3;
   localparam int CLS_BR    = 4;
   localparam int CLS_JAL   = 5;
   localparam int CLS_ILL   = 6;

   // BR/ILL finish in EXEC, STORE in MEM, everything else in WB.
   function automatic logic is_last(input state_e st, input logic [CLS_W-1:0] cls);
      logic last;
      last = 1'b0;
      case (st)
         ST_EXEC: last = cls[CLS_BR] | cls[CLS_ILL];
         ST_MEM:  last = cls[CLS_STORE];
         ST_WB:   last = 1'b1;
         default: last = 1'b0;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/multicycle_ctl_decode.sv
// Opcode classifier for the multi-cycle sequencer.
//  opcode in  7          ir[6:0] of the latched instruction
//  cls    out CLS_W      one-hot class; unknown opcodes map to CLS_ILL
module multicycle_ctl_decode
   import multicycle_ctl_pkg::*;
(
   input  logic [6:0]       opcode,
   output logic [CLS_W-1:0] cls
);

   always_comb begin
      cls = '0;
      case (opcode)
         OPC_R:     cls[CLS_R]     = 1'b1;
         OPC_IALU:  cls[CLS_IALU]  = 1'b1;
         OPC_LOAD:  cls[CLS_LOAD]  = 1'b1;
         OPC_STORE: cls[CLS_STORE] = 1'b1;
         OPC_BR:    cls[CLS_BR]    = 1'b1;
         OPC_JAL:   cls[CLS_JAL]   = 1'b1;
         default:   cls[CLS_ILL]   = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctl.sv
// Multi-cycle sequencer for the yIF/yID/yEX/yDM/yWB RV32 datapath.
// Owns PC and IR, drives per-state datapath strobes, picks the next PC
// and halts after MAX_INSTR retirements (0 = never halt).
//  clk, reset                 clock, synchronous active-high reset
//  start                      leave IDLE (ignored elsewhere)
//  ins, pc_p4                 instruction and PC+4 from yIF
//  imm, j_target              branch immediate / jump offset from yID
//  zero                       ALU zero flag from yEX
//  pc, ir                     current PC, latched instruction
//  RegWrite..Mem2Reg, op      datapath controls (Moore)
//  state, retired, done       debug state, retired count, halted
//  illegal                    sticky unknown-opcode flag
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | ir captured from ins at end of cycle
// DECODE  | class of ir resolved
// EXEC    | ALU cycle; BR/ILL retire here
// MEM     | data memory access; STORE retires here
// WB      | register write-back; R/IALU/JAL/LOAD retire here
// HALT    | instruction budget spent, held until reset
module multicycle_ctl
   import multicycle_ctl_pkg::*;
#(
   parameter logic [31:0] ENTRY_PC  = 32'h28,
   parameter int          MAX_INSTR = 43,
   parameter int          CNT_W     = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      ins,
   input  logic [31:0]      pc_p4,
   input  logic [31:0]      imm,
   input  logic [31:0]      j_target,
   input  logic             zero,
   output logic [31:0]      pc,
   output logic [31:0]      ir,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Mem2Reg,
   output logic [2:0]       op,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic             done,
   output logic             illegal
);

   state_e             state_q, state_d;
   logic [CLS_W-1:0]   cls;
   logic               last;
   logic               halt_now;
   logic               imm_class;
   logic [31:0]        pc_next;
   // Instructions left before HALT; terminal count is 1 on the retiring edge.
   logic [CNT_W-1:0]   remaining;

   multicycle_ctl_decode u_decode (
      .opcode (ir[6:0]),
      .cls    (cls)
   );

   assign last      = is_last(state_q, cls);
   assign halt_now  = (MAX_INSTR != 0) && (remaining == CNT_W'(1));
   assign imm_class = ~(cls[CLS_R] | cls[CLS_BR]);
   assign state     = state_q;
   assign done      = (state_q == ST_HALT);

   always_comb begin
      pc_next = pc_p4;
      if (cls[CLS_JAL])
         pc_next = pc_p4 + (j_target << 2);
      else if (cls[CLS_BR] && zero)
         pc_next = pc_p4 + (imm << 2);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC,
         ST_MEM,
         ST_WB: begin
            if (last)
               state_d = halt_now ? ST_HALT : ST_FETCH;
            else if (state_q == ST_EXEC && (cls[CLS_LOAD] || cls[CLS_STORE]))
               state_d = ST_MEM;
            else
               state_d = ST_WB;
         end
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Mem2Reg  = 1'b0;
      op       = ALU_ADD;
      case (state_q)
         ST_EXEC: begin
            ALUSrc = imm_class;
            if (cls[CLS_BR]) op = ALU_SUB;
         end
         ST_MEM: begin
            ALUSrc   = imm_class;
            MemRead  = cls[CLS_LOAD];
            MemWrite = cls[CLS_STORE];
         end
         ST_WB: begin
            ALUSrc   = imm_class;
            RegWrite = 1'b1;
            Mem2Reg  = cls[CLS_LOAD];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pc        <= ENTRY_PC;
         ir        <= '0;
         retired   <= '0;
         remaining <= CNT_W'(MAX_INSTR);
         illegal   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_FETCH)
            ir <= ins;
         if (last) begin
            pc        <= pc_next;
            retired   <= retired + CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (cls[CLS_ILL])
               illegal <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctl.sv
module tb_multicycle_ctl;

   localparam int MAXI = 3;
   localparam int C_R = 0, C_IALU = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;
   localparam logic [2:0] S_IDLE = 3'd0, S_HALT = 3'd6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] ins = '0, pc_p4 = '0, imm = '0, j_target = '0;
   logic [31:0] pc, ir;
   logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, done, illegal;
   logic [2:0]  op, state;
   logic [15:0] retired;

   multicycle_ctl #(.ENTRY_PC(32'h28), .MAX_INSTR(MAXI), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .ins(ins), .pc_p4(pc_p4),
      .imm(imm), .j_target(j_target), .zero(zero), .pc(pc), .ir(ir),
      .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead),
      .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .op(op), .state(state),
      .retired(retired), .done(done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ncyc;
      logic [39:0] seq;
      logic [31:0] pc;
      int          ret;
      bit          ill;
      bit          done;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   // reference model state
   logic [31:0] pc_m;
   int          ret_m;
   bit          ill_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int n_cycles(input int c);
      case (c)
         C_LOAD:      return 5;
         C_BR, C_ILL: return 3;
         default:     return 4;
      endcase
   endfunction

   // phase: 0 fetch, 1 decode, 2 execute, 3 memory, 4 write-back
   function automatic int phase_of(input int c, input int k);
      if (k < 3) return k;
      if (c == C_LOAD) return k;
      if (c == C_STORE) return 3;
      return 4;
   endfunction

   function automatic logic [7:0] exp_vec(input int c, input int p);
      bit rw = 0, as = 0, mr = 0, mw = 0, m2r = 0;
      logic [2:0] o = 3'b010;
      if (p >= 2) as = !(c == C_R || c == C_BR);
      if (p == 2 && c == C_BR) o = 3'b110;
      if (p == 3) begin mr = (c == C_LOAD); mw = (c == C_STORE); end
      if (p == 4) begin rw = 1; m2r = (c == C_LOAD); end
      return {rw, as, mr, mw, m2r, o};
   endfunction

   function automatic logic [6:0] opc_of(input int c);
      case (c)
         C_R:     return 7'h33;
         C_IALU:  return 7'h13;
         C_LOAD:  return 7'h03;
         C_STORE: return 7'h23;
         C_BR:    return 7'h63;
         C_JAL:   return 7'h6f;
         default: return 7'h7f;
      endcase
   endfunction

   function automatic logic [31:0] rand_word(input int c);
      logic [6:0] o;
      o = opc_of(c);
      if (c == C_ILL) begin
         o = 7'($urandom_range(0, 127));
         while (o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h63 || o == 7'h6f)
            o = 7'($urandom_range(0, 127));
      end
      return ($urandom() & 32'hffff_ff80) | {25'd0, o};
   endfunction

   // Model one instruction, queue its expected retirement, then drive it.
   task automatic run_instr(input int c, input logic [31:0] word, input logic [31:0] p4,
                            input logic [31:0] im, input logic [31:0] jt, input bit z);
      exp_t e;
      int   n;
      n = n_cycles(c);
      e.ncyc = n;
      e.seq  = '0;
      for (int k = 0; k < n; k++) e.seq = (e.seq << 8) | {32'd0, exp_vec(c, phase_of(c, k))};
      if (c == C_JAL)           pc_m = p4 + jt * 4;
      else if (c == C_BR && z)  pc_m = p4 + im * 4;
      else                      pc_m = p4;
      ret_m++;
      if (c == C_ILL) ill_m = 1;
      e.pc = pc_m; e.ret = ret_m; e.ill = ill_m; e.done = (ret_m == MAXI);
      q.push_back(e);
      for (int k = 0; k < n; k++) begin
         #1;
         start    = 1'b0;
         ins      = (k == 0) ? word : $urandom();
         zero     = (k == 2) ? z : 1'($urandom_range(0, 1));
         pc_p4    = p4;
         imm      = im;
         j_target = jt;
         @(posedge clk);
      end
   endtask

   task automatic run_rand(input int c);
      run_instr(c, rand_word(c), pc_m + 32'd4, $urandom_range(0, 64) - 32,
                $urandom(), 1'($urandom_range(0, 1)));
   endtask

   // Caller sits at a negedge; reset is asserted mid-cycle.
   task automatic do_reset();
      #1;
      reset = 1'b1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_state", state, S_IDLE);
      check("rst_pc", pc, 32'h28);
      check("rst_ir", ir, 0);
      check("rst_retired", retired, 0);
      check("rst_done_illegal", {done, illegal}, 0);
      check("rst_strobes", {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op}, 8'h02);
      pc_m = 32'h28; ret_m = 0; ill_m = 0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic begin_episode();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(negedge clk);
      check("idle_wait", state, S_IDLE);
      #1 start = 1'b1;
      @(posedge clk);
   endtask

   task automatic halt_check();
      @(negedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("halt_state", state, S_HALT);
      check("halt_done", done, 1);
      check("halt_pc", pc, pc_m);
      check("halt_retired", retired, MAXI);
   endtask

   // Monitor: accumulates per-cycle controls and checks on each retirement.
   logic [39:0] acc_seq;
   int          acc_n;
   logic [15:0] prev_ret;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         acc_seq  = '0;
         acc_n    = 0;
         prev_ret = retired;
      end else begin
         if (retired !== prev_ret) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_retire: retired=%0d with no expectation", retired);
            end else begin
               e = q.pop_front();
               check("cycles", acc_n, e.ncyc);
               check("ctl_seq", acc_seq, e.seq);
               check("pc", pc, e.pc);
               check("retired", retired, e.ret);
               check("illegal", illegal, e.ill);
               check("done", done, e.done);
            end
            acc_seq  = '0;
            acc_n    = 0;
            prev_ret = retired;
         end
         if (state != S_IDLE && state != S_HALT) begin
            acc_seq = (acc_seq << 8) | {32'd0, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op};
            acc_n++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pc_m = 32'h28; ret_m = 0; ill_m = 0;
      @(negedge clk);
      do_reset();

      // add, lw, sw -> halt
      begin_episode();
      run_instr(C_R,     32'h0020_81b3, pc_m + 4, 0, 0, 0);
      run_instr(C_LOAD,  32'h0000_a183, pc_m + 4, 0, 0, 0);
      run_instr(C_STORE, 32'h0030_a023, pc_m + 4, 0, 0, 0);
      halt_check();
      do_reset();

      // add, beq taken (pc_p4=0x30, imm=3), beq not taken
      begin_episode();
      run_instr(C_R,  32'h0020_81b3, pc_m + 4, 0, 0, 0);
      run_instr(C_BR, 32'h0000_0063, 32'h30, 3, 0, 1);
      run_instr(C_BR, 32'h0000_0063, pc_m + 4, 3, 0, 0);
      halt_check();
      do_reset();

      // jal backwards, illegal opcode, add
      begin_episode();
      run_instr(C_JAL, 32'h0000_006f, 32'h40, 0, 32'hffff_fffe, 0);
      run_instr(C_ILL, 32'h0000_007f, pc_m + 4, 0, 0, 0);
      run_instr(C_R,   32'h0020_81b3, pc_m + 4, 0, 0, 0);
      halt_check();
      do_reset();

      // three R-types -> halt after 12 cycles
      begin_episode();
      for (int i = 0; i < 3; i++) run_instr(C_R, rand_word(C_R), pc_m + 4, 0, 0, 0);
      halt_check();
      do_reset();

      // reset while a load sits in MEM
      begin_episode();
      for (int k = 0; k < 3; k++) begin
         #1 start = 1'b0;
         ins = 32'h0000_a183;
         @(posedge clk);
      end
      @(negedge clk);
      check("mid_load_memread", MemRead, 1);
      do_reset();

      for (int ep = 0; ep < 25; ep++) begin
         int n;
         n = $urandom_range(1, 3);
         begin_episode();
         for (int i = 0; i < n; i++) run_rand($urandom_range(0, 6));
         if (n == MAXI) halt_check();
         else begin
            if ($urandom_range(0, 1) == 1) begin
               int c, m;
               c = $urandom_range(0, 6);
               m = $urandom_range(1, n_cycles(c) - 1);
               for (int k = 0; k < m; k++) begin
                  #1 ins = rand_word(c);
                  @(posedge clk);
               end
            end
            @(negedge clk);
         end
         do_reset();
      end

      repeat (3) @(posedge clk);
      check("scoreboard_drain", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
